// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: holds one instruction, waits for the data-SRAM response,
// aligns/extends load data, drops responses owned by flushed requests and
// drives the ID bypass/stall signals.
module mem_stage_lsu #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DEST_W   = 5,
    parameter int unsigned CANCEL_W = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              ws_allowin,
    output logic              ms_allowin,
    input  logic              es_to_ms_valid,
    input  logic [2:0]        es_ld_op,
    input  logic              es_res_from_mem,
    input  logic              es_mem_req,
    input  logic              es_gr_we,
    input  logic [DEST_W-1:0] es_dest,
    input  logic [DATA_W-1:0] es_alu_result,
    input  logic [ADDR_W-1:0] es_pc,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    output logic              ms_to_ws_valid,
    output logic              ms_gr_we,
    output logic [DEST_W-1:0] ms_dest,
    output logic [DATA_W-1:0] ms_final_result,
    output logic [ADDR_W-1:0] ms_pc,
    output logic [DEST_W-1:0] ms_fwd_dest,
    output logic [DATA_W-1:0] ms_fwd_result,
    output logic              ms_fwd_stall
);

    localparam int unsigned OFF_W = $clog2(DATA_W / 8);
    localparam int unsigned SH_W  = OFF_W + 3;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                ms_valid_q, ms_valid_d;
    logic [CANCEL_W-1:0] cancel_q, cancel_d;
    logic [2:0]          ld_op_q, ld_op_d;
    logic                res_from_mem_q, res_from_mem_d;
    logic                gr_we_q, gr_we_d;
    logic [DEST_W-1:0]   dest_q, dest_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   rbuf_q, rbuf_d;

    logic                capture;
    logic                stale;
    logic                cancel_inc;
    logic                ready_go;
    logic                accept;
    logic                leave;
    logic [DATA_W-1:0]   rdata_sel;
    logic [SH_W-1:0]     shamt;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   aligned;

    // Handshake: a live response is consumed only when no stale ones are owed
    assign capture    = (state_q == S_WAIT) & data_sram_data_ok & (cancel_q == '0);
    assign stale      = data_sram_data_ok & (cancel_q != '0);
    assign cancel_inc = flush & (state_q == S_WAIT) & ~capture;
    assign ready_go   = (state_q == S_READY) | capture;
    assign ms_allowin = ~ms_valid_q | (ready_go & ws_allowin);
    assign accept     = es_to_ms_valid & ms_allowin & ~flush;
    assign leave      = ms_valid_q & ready_go & ws_allowin;
    assign ms_to_ws_valid = ms_valid_q & ready_go;

    // Same-cycle response data bypasses the buffer for a zero-bubble hand-off
    assign rdata_sel = capture ? data_sram_rdata : rbuf_q;
    assign shamt     = {alu_q[OFF_W-1:0], 3'b000};
    assign shifted   = rdata_sel >> shamt;

    // Sub-word extraction and sign/zero extension
    always_comb begin
        aligned = shifted;
        case (ld_op_q)
            3'b000:  aligned = DATA_W'($signed(shifted[7:0]));
            3'b001:  aligned = DATA_W'(shifted[7:0]);
            3'b010:  aligned = DATA_W'($signed(shifted[15:0]));
            3'b011:  aligned = DATA_W'(shifted[15:0]);
            3'b101:  aligned = DATA_W'(shifted[31:0]);
            3'b110:  aligned = shifted;
            default: aligned = DATA_W'($signed(shifted[31:0]));
        endcase
    end

    // Next-state: flush beats accept; accept beats leave; capture buffers data
    always_comb begin
        state_d        = state_q;
        ms_valid_d     = ms_valid_q;
        cancel_d       = cancel_q;
        ld_op_d        = ld_op_q;
        res_from_mem_d = res_from_mem_q;
        gr_we_d        = gr_we_q;
        dest_d         = dest_q;
        alu_d          = alu_q;
        pc_d           = pc_q;
        rbuf_d         = rbuf_q;

        if (stale) begin
            cancel_d = cancel_q - CANCEL_W'(1);
        end
        if (cancel_inc && (cancel_d != '1)) begin
            cancel_d = cancel_d + CANCEL_W'(1);
        end

        if (capture) begin
            rbuf_d = data_sram_rdata;
        end

        if (flush) begin
            ms_valid_d = 1'b0;
            state_d    = S_EMPTY;
        end else if (accept) begin
            ms_valid_d     = 1'b1;
            state_d        = es_mem_req ? S_WAIT : S_READY;
            ld_op_d        = es_ld_op;
            res_from_mem_d = es_res_from_mem;
            gr_we_d        = es_gr_we;
            dest_d         = es_dest;
            alu_d          = es_alu_result;
            pc_d           = es_pc;
        end else if (leave) begin
            ms_valid_d = 1'b0;
            state_d    = S_EMPTY;
        end else if (capture) begin
            state_d = S_READY;
        end
    end

    // State and latched-field registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_EMPTY;
            ms_valid_q     <= 1'b0;
            cancel_q       <= '0;
            ld_op_q        <= '0;
            res_from_mem_q <= 1'b0;
            gr_we_q        <= 1'b0;
            dest_q         <= '0;
            alu_q          <= '0;
            pc_q           <= '0;
            rbuf_q         <= '0;
        end else begin
            state_q        <= state_d;
            ms_valid_q     <= ms_valid_d;
            cancel_q       <= cancel_d;
            ld_op_q        <= ld_op_d;
            res_from_mem_q <= res_from_mem_d;
            gr_we_q        <= gr_we_d;
            dest_q         <= dest_d;
            alu_q          <= alu_d;
            pc_q           <= pc_d;
            rbuf_q         <= rbuf_d;
        end
    end

    assign ms_gr_we        = gr_we_q;
    assign ms_dest         = dest_q;
    assign ms_pc           = pc_q;
    assign ms_final_result = res_from_mem_q ? aligned : alu_q;
    assign ms_fwd_dest     = (ms_valid_q & gr_we_q) ? dest_q : '0;
    assign ms_fwd_result   = ms_final_result;
    assign ms_fwd_stall    = ms_valid_q & res_from_mem_q & ~ready_go;

endmodule
